l2_ifill_resp: RTL and testbench

Responder end of the L1I refill interface: accepts a single blocking word-refill request from `l1i`, looks it up in a direct-mapped L2 instruction array, and returns the 32-bit instruction word with a one-cycle response pulse. On an L2 miss it fetches the word from the backing memory port, installs it, then responds. It sits between `l1i` and the memory/bus side of the `riscv32i_3d` instruction path.

---
 rtl/l2_ifill_pkg.sv | 31 +++
 rtl/l2_ifill_resp_if.sv | 27 ++
 rtl/l2_ifill_array.sv | 27 ++
 rtl/l2_ifill_resp.sv | 124 ++++++++++++
 tb/tb_l2_ifill_resp.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/l2_ifill_pkg.sv
// rtl/l2_ifill_pkg.sv - shared types and widths for the L2 instruction refill responder
// Contents: address/data/index widths, derived tag width and line count,
// FSM state enum, and address-split helpers used by the top and the interface.
package l2_ifill_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int IDX_W  = 8;
    localparam int TAG_W  = ADDR_W - IDX_W - 2;
    localparam int LINES  = 2 ** IDX_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_MEM_WAIT,
        ST_FILL,
        ST_RESP,
        ST_DONE
    } state_t;

    // Word address (byte offset already stripped) -> line index
    function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:2] waddr);
        return waddr[IDX_W+1:2];
    endfunction

    // Word address -> tag
    function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:2] waddr);
        return waddr[ADDR_W-1:IDX_W+2];
    endfunction

endpackage

// File: rtl/l2_ifill_resp_if.sv
// rtl/l2_ifill_resp_if.sv - L1I refill request/response and backing-memory read bundle
// Signals: req_valid_i/req_addr_i (refill request), resp_valid_o/resp_dat_o (response pulse),
// mem_req_o/mem_addr_o (memory read request), mem_ack_i/mem_dat_i (memory return).
// Modports: master = requester and memory model side, slave = l2_ifill_resp.
interface l2_ifill_resp_if;
    import l2_ifill_pkg::*;

    logic              req_valid_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic              resp_valid_o;
    logic [DATA_W-1:0] resp_dat_o;
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_dat_i;

    modport master (
        output req_valid_i, req_addr_i, mem_ack_i, mem_dat_i,
        input  resp_valid_o, resp_dat_o, mem_req_o, mem_addr_o
    );

    modport slave (
        input  req_valid_i, req_addr_i, mem_ack_i, mem_dat_i,
        output resp_valid_o, resp_dat_o, mem_req_o, mem_addr_o
    );

endinterface

// File: rtl/l2_ifill_array.sv
// rtl/l2_ifill_array.sv - direct-mapped L2 tag+data store, single port, one-cycle read
// Ports: clk; idx (line select for read and write); we (write enable);
// wdata ({tag, data}); rdata ({tag, data} of idx registered at the previous edge).
// No reset: line validity is tracked by the parent.
module l2_ifill_array
    import l2_ifill_pkg::*;
#(
    parameter int AW = IDX_W,
    parameter int W  = TAG_W + DATA_W
) (
    input  logic          clk,
    input  logic [AW-1:0] idx,
    input  logic          we,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        rdata <= mem[idx];
    end

endmodule

// File: rtl/l2_ifill_resp.sv
// rtl/l2_ifill_resp.sv - L1I refill responder with direct-mapped L2 and memory refill on miss
// Ports: clk; rst (synchronous, active high); bus (l2_ifill_resp_if.slave).
// Optional macro L2_IFILL_STATS_EN adds hit_cnt_o / miss_cnt_o saturating 32-bit counters.
module l2_ifill_resp
    import l2_ifill_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    l2_ifill_resp_if.slave    bus
`ifdef L2_IFILL_STATS_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);

    state_t                   state;
    logic [ADDR_W-1:2]        addr_q;
    logic [DATA_W-1:0]        data_q;
    logic [LINES-1:0]         valid;

    logic [IDX_W-1:0]         arr_idx;
    logic                     arr_we;
    logic [TAG_W+DATA_W-1:0]  arr_wdata;
    logic [TAG_W+DATA_W-1:0]  arr_rdata;
    logic                     hit;
    logic                     unused_req_lsb;

    assign unused_req_lsb = ^bus.req_addr_i[1:0];

    // The array read is launched from the live request address while idle so
    // the stored tag/data are ready in LOOKUP; otherwise the latched address
    // drives the port (FILL writes to the same line that was looked up).
    assign arr_idx   = (state == ST_IDLE) ? idx_of(bus.req_addr_i[ADDR_W-1:2]) : idx_of(addr_q);
    assign arr_we    = (state == ST_FILL);
    assign arr_wdata = {tag_of(addr_q), data_q};
    assign hit       = valid[idx_of(addr_q)] && (arr_rdata[TAG_W+DATA_W-1:DATA_W] == tag_of(addr_q));

    l2_ifill_array u_array (
        .clk   (clk),
        .idx   (arr_idx),
        .we    (arr_we),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            addr_q           <= '0;
            data_q           <= '0;
            valid            <= '0;
            bus.resp_valid_o <= 1'b0;
            bus.resp_dat_o   <= '0;
            bus.mem_req_o    <= 1'b0;
            bus.mem_addr_o   <= '0;
        end else begin
            bus.resp_valid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid_i) begin
                        addr_q <= bus.req_addr_i[ADDR_W-1:2];
                        state  <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (hit) begin
                        data_q <= arr_rdata[DATA_W-1:0];
                        state  <= ST_RESP;
                    end else begin
                        state  <= ST_MEM_WAIT;
                    end
                end
                ST_MEM_WAIT: begin
                    // First MEM_WAIT edge raises the request; an ack only
                    // counts once the request is actually visible on the port.
                    if (!bus.mem_req_o) begin
                        bus.mem_req_o  <= 1'b1;
                        bus.mem_addr_o <= {addr_q, 2'b00};
                    end else if (bus.mem_ack_i) begin
                        data_q        <= bus.mem_dat_i;
                        bus.mem_req_o <= 1'b0;
                        state         <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    valid[idx_of(addr_q)] <= 1'b1;
                    state                 <= ST_RESP;
                end
                ST_RESP: begin
                    bus.resp_valid_o <= 1'b1;
                    bus.resp_dat_o   <= data_q;
                    state            <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef L2_IFILL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else if (state == ST_LOOKUP) begin
            if (hit) begin
                if (hit_cnt_o != 32'hFFFF_FFFF) begin
                    hit_cnt_o <= hit_cnt_o + 32'd1;
                end
            end else begin
                if (miss_cnt_o != 32'hFFFF_FFFF) begin
                    miss_cnt_o <= miss_cnt_o + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_l2_ifill_resp.sv
// tb/tb_l2_ifill_resp.sv - scoreboard testbench for l2_ifill_resp (optional L2_IFILL_STATS_EN)
module tb_l2_ifill_resp;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;
    bit   prev_rv;
    exp_t exp_q[$];

    l2_ifill_resp_if bus ();

`ifdef L2_IFILL_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    l2_ifill_resp dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus)
`ifdef L2_IFILL_STATS_EN
        ,
        .hit_cnt_o  (hit_cnt),
        .miss_cnt_o (miss_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s act=%h exp=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Response monitor: every resp_valid_o pulse must match the oldest
    // expectation in data and in the edge at which it appeared.
    always @(negedge clk) begin
        if (!rst && bus.resp_valid_o) begin
            chk("resp_single_pulse", 32'(prev_rv), 32'd0);
            chk("resp_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_dat", bus.resp_dat_o, e.data);
                chk("resp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        prev_rv = bus.resp_valid_o;
    end

    // One blocking refill. miss selects the memory path; tied means
    // mem_ack_i is already held high by the caller.
    task automatic do_req(input logic [31:0] addr, input logic [31:0] data,
                          input bit miss, input int ack_dly, input bit tied);
        int  n;
        int  waitc;
        bit  seen;
        bit  mreq_seen;
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = addr;
        if (tied) bus.mem_dat_i = data;
        n = cyc + 1;
        if (!miss)     exp_q.push_back('{data, n + 2});
        else if (tied) exp_q.push_back('{data, n + 5});
        @(negedge clk);
        bus.req_addr_i = addr ^ 32'h0000_0C04;
        @(negedge clk);
        chk("mem_req_lookup", 32'(bus.mem_req_o), 32'd0);
        mreq_seen = 1'b0;
        if (miss) begin
            @(negedge clk);
            chk("mem_req_rise", 32'(bus.mem_req_o), 32'd1);
            chk("mem_addr", bus.mem_addr_o, addr & 32'hFFFF_FFFC);
            if (tied) begin
                @(negedge clk);
                chk("mem_req_one_cycle", 32'(bus.mem_req_o), 32'd0);
            end else begin
                repeat (ack_dly) @(negedge clk);
                chk("mem_req_hold", 32'(bus.mem_req_o), 32'd1);
                bus.mem_ack_i = 1'b1;
                bus.mem_dat_i = data;
                exp_q.push_back('{data, cyc + 3});
                @(negedge clk);
                bus.mem_ack_i = 1'b0;
                bus.mem_dat_i = 32'h0BAD_0BAD;
                chk("mem_req_drop", 32'(bus.mem_req_o), 32'd0);
            end
        end
        seen  = 1'b0;
        waitc = 0;
        while (!seen && waitc < 40) begin
            if (bus.resp_valid_o) begin
                seen = 1'b1;
            end else begin
                mreq_seen = mreq_seen | bus.mem_req_o;
                @(negedge clk);
                waitc = waitc + 1;
            end
        end
        chk("resp_seen", 32'(seen), 32'd1);
        if (!miss) chk("hit_no_mem_req", 32'(mreq_seen), 32'd0);
        bus.req_valid_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        prev_rv         = 1'b0;
        rst             = 1'b1;
        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = '0;
        bus.mem_ack_i   = 1'b0;
        bus.mem_dat_i   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_resp_valid", 32'(bus.resp_valid_o), 32'd0);
        chk("rst_resp_dat",   bus.resp_dat_o,         32'd0);
        chk("rst_mem_req",    32'(bus.mem_req_o),    32'd0);
        chk("rst_mem_addr",   bus.mem_addr_o,         32'd0);
`ifdef L2_IFILL_STATS_EN
        chk("rst_hit_cnt",  hit_cnt,  32'd0);
        chk("rst_miss_cnt", miss_cnt, 32'd0);
`endif

        do_req(32'h0000_1004, 32'hDEAD_BEEF, 1'b1, 3, 1'b0);
        do_req(32'h0000_1004, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
        do_req(32'h0000_1006, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
`ifdef L2_IFILL_STATS_EN
        chk("hit_cnt",  hit_cnt,  32'd2);
        chk("miss_cnt", miss_cnt, 32'd1);
`endif

        do_req(32'h0000_1404, 32'h1234_5678, 1'b1, 1, 1'b0);
        do_req(32'h0000_1404, 32'h1234_5678, 1'b0, 0, 1'b0);
        do_req(32'h0000_1004, 32'hDEAD_BEEF, 1'b1, 0, 1'b0);

        bus.mem_ack_i = 1'b1;
        do_req(32'h0000_3010, 32'hCAFE_F00D, 1'b1, 0, 1'b1);
        bus.mem_dat_i = 32'h5A5A_5A5A;
        repeat (4) @(negedge clk);
        chk("idle_ack_mem_req", 32'(bus.mem_req_o),    32'd0);
        chk("idle_ack_resp",    32'(bus.resp_valid_o), 32'd0);
        chk("idle_ack_dat",     bus.resp_dat_o,         32'hCAFE_F00D);
        do_req(32'h0000_3010, 32'hCAFE_F00D, 1'b0, 0, 1'b1);
        bus.mem_ack_i = 1'b0;

        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = 32'h0000_2008;
        repeat (3) @(negedge clk);
        chk("rst_wait_mem_req_up", 32'(bus.mem_req_o), 32'd1);
        rst             = 1'b1;
        bus.req_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_wait_mem_req_down", 32'(bus.mem_req_o),    32'd0);
        chk("rst_wait_resp",         32'(bus.resp_valid_o), 32'd0);
        bus.mem_ack_i = 1'b1;
        bus.mem_dat_i = 32'h5555_AAAA;
        @(negedge clk);
        bus.mem_ack_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("late_ack_mem_req", 32'(bus.mem_req_o),    32'd0);
        chk("late_ack_resp",    32'(bus.resp_valid_o), 32'd0);
        do_req(32'h0000_2008, 32'h7777_0001, 1'b1, 2, 1'b0);
        do_req(32'h0000_1004, 32'hDEAD_BEEF, 1'b1, 1, 1'b0);
        do_req(32'h0000_2008, 32'h7777_0001, 1'b0, 0, 1'b0);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
